axil_portb_master: RTL and testbench
====================================

# axil_portb_master

AXI4-Lite slave that turns PS-side register accesses into Port B transactions (addr_b/din_b/we_b/dout_b) on the single-cycle RISC-V core's shared instruction/data memories. It is the initiator end of the Port B interface. Port B decodes addresses below 0x2000 to instruction memory and all others to data memory. Every write pulse on we_b also holds the core in reset for that cycle. One transaction is in flight at a time; a write is a one-cycle we_b pulse and a read is a timed sample of dout_b.

## Interface
Parameters:
- ADDR_W, 16: AXI address width; addr_b is zero-extended to 32 bits.
- RD_LAT, 1: cycles from addr_b stable to dout_b valid (0 = combinational read).
- MEM_LIMIT, 32'h4000: first out-of-range byte address; used only when the address check is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  ignored; every write is a full word.
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake.
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.
- addr_b  out  32  Port B address.
- din_b  out  32  Port B write data.
- we_b  out  1  Port B write enable, one-cycle pulse.
- dout_b  in  32  Port B read data.

## Operation
FSM states: IDLE, WR_ISSUE, WR_RESP, RD_WAIT, RD_RESP.
- IDLE:
  - awready = 1 while AW is not yet latched; wready = 1 while W is not yet latched. AW and W are accepted in either order or in the same cycle.
  - Once both are latched, go to WR_ISSUE.
  - arready = 1 only when nothing of a write is latched and awvalid = wvalid = 0. Writes win on simultaneous AW/W/AR.
  - On an AR handshake, go to RD_WAIT.
- Address mapping: addr_b = {zero-ext, addr[ADDR_W-1:2], 2'b00}. The low two address bits are dropped.
- WR_ISSUE: drive addr_b and din_b; we_b = 1 for exactly this cycle; then go to WR_RESP.
- WR_RESP: bvalid = 1, held until bready = 1; then return to IDLE.
- RD_WAIT:
  - addr_b held, we_b = 0, for RD_LAT+1 cycles.
  - On the last cycle, capture dout_b into rdata and go to RD_RESP.
- RD_RESP: rvalid = 1 with rdata and rresp stable until rready = 1; then return to IDLE.
- bresp/rresp = 2'b00 (OKAY) unless the address check is compiled in and rejects the access.
- wstrb is ignored; partial writes are not supported.

## Timing
- Reset values: all ready/valid outputs 0, bresp = rresp = 0, rdata = 0, addr_b = din_b = 0, we_b = 0, state IDLE, latch flags cleared.
- Write latency (AW and W handshake in cycle 0):
  - we_b = 1 in cycle 1.
  - bvalid = 1 in cycle 2.
  - Earliest next AW/W accept is the cycle after the B handshake.
- Read latency (AR handshake in cycle 0):
  - addr_b valid in cycle 1.
  - rdata sampled at the end of cycle 1+RD_LAT.
  - rvalid = 1 in cycle 2+RD_LAT (RD_LAT = 1 gives cycle 3).
- No combinational path from any AXI input to any AXI output.
- we_b never asserts in any state other than WR_ISSUE.
- Backpressure: bvalid/rvalid may be held indefinitely; no new handshake is accepted meanwhile.
- Reset mid-transaction (rst = 0 in any cycle):
  - The transaction is dropped with no response.
  - we_b = 0 from the next edge.
  - A we_b pulse already in progress completes only if its cycle has already started.

## Configuration
- PORTB_ADDR_CHECK_EN defined:
  - An address ≥ MEM_LIMIT suppresses the Port B access: we_b stays 0 in WR_ISSUE, and the RD_WAIT capture is skipped.
  - The response is 2'b10 (SLVERR), with rdata = 0.
  - Handshake timing is unchanged.
- PORTB_ADDR_CHECK_EN undefined: every address is forwarded and the response is always OKAY. MEM_LIMIT is unused.

## Structure
- Shared package portb_bridge_pkg holds:
  - the state enum (IDLE, WR_ISSUE, WR_RESP, RD_WAIT, RD_RESP);
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - DMEM_BASE = 32'h2000, shared with the core's Port B decode.
- No sub-module: one FSM plus AW/W latches and a read-wait counter sized $clog2(RD_LAT+2).

## Test plan
- Write AW = 0x0010 and W = 0xDEADBEEF in the same cycle, bready = 1 → we_b pulses once in cycle 1 with addr_b = 0x10 and din_b = 0xDEADBEEF; bvalid in cycle 2 with bresp = 0.
- W first (0x12345678), AW = 0x2004 three cycles later → a single we_b pulse to addr_b = 0x2004 the cycle after AW; no early pulse.
- Read araddr = 0x2004 with a memory model of RD_LAT = 1 returning 0x12345678 → rvalid in cycle 3 with rdata = 0x12345678; rready held 0 for 5 cycles → rdata stable, arready = 0.
- AW, W and AR valid in the same cycle → the write completes first, then arready = 1 and the read returns the newly written data.
- Reset asserted during RD_WAIT → next cycle all valids are 0, no rvalid appears, and a fresh read succeeds.
- With PORTB_ADDR_CHECK_EN, write to 0x4000 → no we_b, bresp = 2'b10; read of 0x4000 → rresp = 2'b10, rdata = 0.

Source files
------------

// File: rtl/portb_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to Port B bridge and the core's Port B decode.
package portb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_WAIT,
    RD_RESP
  } state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Port B sends addresses below this to instruction memory, the rest to data memory.
  localparam logic [31:0] DMEM_BASE   = 32'h2000;

endpackage

// File: rtl/axil_portb_master.sv
// AXI4-Lite slave that issues single Port B reads/writes into the core's memories.
// Optional out-of-range address rejection is compiled in with PORTB_ADDR_CHECK_EN.
module axil_portb_master
  import portb_bridge_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] MEM_LIMIT = 32'h4000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       addr_b,
  output logic [31:0]       din_b,
  output logic              we_b,
  input  logic [31:0]       dout_b
);

  localparam int              CNT_W    = $clog2(RD_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

  function automatic logic [31:0] map_addr(input logic [ADDR_W-3:0] word);
    return 32'({word, 2'b00});
  endfunction

  state_e            state_q, state_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-3:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_err_q, rd_err_d;
  logic [31:0]       addr_b_q, addr_b_d, din_b_q, din_b_d, rdata_q, rdata_d;
  logic              we_b_q, we_b_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;

  logic              aw_hs, w_hs, ar_hs, wr_err, rd_err;
  logic [31:0]       wr_addr, rd_addr;

  // Inputs with no function in this bridge; wstrb is ignored, low address bits dropped.
  logic              unused_inputs;
  assign unused_inputs = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0], MEM_LIMIT};

  always_comb begin
    state_d   = state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rd_err_d  = rd_err_q;
    addr_b_d  = addr_b_q;
    din_b_d   = din_b_q;
    rdata_d   = rdata_q;
    we_b_d    = 1'b0;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    arready_d = 1'b0;

    aw_hs   = awready_q & s_axi_awvalid;
    w_hs    = wready_q & s_axi_wvalid;
    ar_hs   = arready_q & s_axi_arvalid;
    wr_addr = map_addr(aw_hs ? s_axi_awaddr[ADDR_W-1:2] : awaddr_q);
    rd_addr = map_addr(s_axi_araddr[ADDR_W-1:2]);
`ifdef PORTB_ADDR_CHECK_EN
    wr_err  = (wr_addr >= MEM_LIMIT);
    rd_err  = (rd_addr >= MEM_LIMIT);
`else
    wr_err  = 1'b0;
    rd_err  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = s_axi_awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_axi_wdata;
        end
        if (aw_got_d && w_got_d) begin
          state_d  = WR_ISSUE;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          addr_b_d = wr_addr;
          din_b_d  = wdata_d;
          we_b_d   = ~wr_err;
          bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (ar_hs) begin
          state_d  = RD_WAIT;
          addr_b_d = rd_addr;
          cnt_d    = '0;
          rd_err_d = rd_err;
        end else if (!aw_got_d && !w_got_d && !s_axi_awvalid && !s_axi_wvalid &&
                     s_axi_arvalid) begin
          // Readies are registered: a read is offered only after a cycle with no write pending.
          arready_d = 1'b1;
        end else begin
          awready_d = ~aw_got_d;
          wready_d  = ~w_got_d;
        end
      end
      WR_ISSUE: begin
        state_d  = WR_RESP;
        bvalid_d = 1'b1;
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = RD_RESP;
          rvalid_d = 1'b1;
          rdata_d  = rd_err_q ? 32'h0 : dout_b;
          rresp_d  = rd_err_q ? RESP_SLVERR : RESP_OKAY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_RESP: begin
        if (s_axi_rready) begin
          state_d   = IDLE;
          rvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_err_q  <= 1'b0;
      addr_b_q  <= '0;
      din_b_q   <= '0;
      rdata_q   <= '0;
      we_b_q    <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rd_err_q  <= rd_err_d;
      addr_b_q  <= addr_b_d;
      din_b_q   <= din_b_d;
      rdata_q   <= rdata_d;
      we_b_q    <= we_b_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign addr_b        = addr_b_q;
  assign din_b         = din_b_q;
  assign we_b          = we_b_q;

endmodule

// File: tb/tb_axil_portb_master.sv
// Scoreboard bench for axil_portb_master with a one-cycle-latency Port B memory model.
module tb_axil_portb_master;
  import portb_bridge_pkg::*;

  localparam int ADDR_W = 16;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] s_axi_awaddr, s_axi_araddr;
  logic              s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0]       s_axi_wdata, s_axi_rdata;
  logic [3:0]        s_axi_wstrb;
  logic [1:0]        s_axi_bresp, s_axi_rresp;
  logic              s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic              s_axi_rvalid, s_axi_rready;
  logic [31:0]       addr_b, din_b, dout_b;
  logic              we_b;

  axil_portb_master #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MEM_LIMIT(32'h4000)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .addr_b(addr_b), .din_b(din_b), .we_b(we_b), .dout_b(dout_b)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Port B memory: registered read, so data follows addr_b by one cycle.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (we_b) mem[addr_b[13:2]] <= din_b;
    dout_b <= mem[addr_b[13:2]];
  end

  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } we_exp_t;
  typedef struct { int cyc; logic [1:0] resp; } b_exp_t;
  typedef struct { int cyc; logic [31:0] data; logic [1:0] resp; } r_exp_t;

  we_exp_t exp_we[$];
  b_exp_t  exp_b[$];
  r_exp_t  exp_r[$];

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: compares every Port B pulse and AXI response against the queued expectations.
  initial begin
    bit b_seen = 0;
    bit r_seen = 0;
    we_exp_t we_e;
    b_exp_t  b_e;
    r_exp_t  r_e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        b_seen = 0;
        r_seen = 0;
      end else begin
        if (we_b) begin
          if (exp_we.size() == 0) chk("we_b_unexpected", 32'(we_b), 32'h0);
          else begin
            we_e = exp_we.pop_front();
            chk("we_b_cycle", 32'(cyc), 32'(we_e.cyc));
            chk("we_b_addr", addr_b, we_e.addr);
            chk("we_b_din", din_b, we_e.data);
          end
        end
        if (s_axi_bvalid && !b_seen) begin
          b_seen = 1;
          if (exp_b.size() == 0) chk("bvalid_unexpected", 32'(s_axi_bvalid), 32'h0);
          else chk("bvalid_cycle", 32'(cyc), 32'(exp_b[0].cyc));
        end
        if (s_axi_bvalid && s_axi_bready) begin
          b_seen = 0;
          if (exp_b.size() != 0) begin
            b_e = exp_b.pop_front();
            chk("bresp", 32'(s_axi_bresp), 32'(b_e.resp));
          end
        end
        if (s_axi_rvalid && !r_seen) begin
          r_seen = 1;
          if (exp_r.size() == 0) chk("rvalid_unexpected", 32'(s_axi_rvalid), 32'h0);
          else chk("rvalid_cycle", 32'(cyc), 32'(exp_r[0].cyc));
        end
        if (s_axi_rvalid && s_axi_rready) begin
          r_seen = 0;
          if (exp_r.size() != 0) begin
            r_e = exp_r.pop_front();
            chk("rdata", s_axi_rdata, r_e.data);
            chk("rresp", 32'(s_axi_rresp), 32'(r_e.resp));
          end
        end
      end
    end
  end

  // AW is presented w_lead cycles after W (0 = same cycle); returns after the B handshake.
  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input int w_lead,
                           input logic [1:0] resp, input bit exp_pulse);
    bit aw_done = 0;
    bit w_done = 0;
    bit b_done = 0;
    int k = 0;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = d;
    s_axi_awaddr = a;
    while (!(aw_done && w_done) && k < 50) begin
      if (k == w_lead) s_axi_awvalid = 1'b1;
      @(negedge clk);
      if (s_axi_awvalid && s_axi_awready) aw_done = 1;
      if (s_axi_wvalid && s_axi_wready) w_done = 1;
      if (aw_done && w_done) begin
        if (exp_pulse) exp_we.push_back('{cyc + 1, {16'h0, a[15:2], 2'b00}, d});
        exp_b.push_back('{cyc + 2, resp});
      end
      @(posedge clk); #1;
      if (aw_done) s_axi_awvalid = 1'b0;
      if (w_done) s_axi_wvalid = 1'b0;
      k++;
    end
    chk("wr_handshake", 32'({aw_done, w_done}), 32'h3);
    for (int i = 0; i < 50 && !b_done; i++) begin
      @(negedge clk);
      if (s_axi_bvalid && s_axi_bready) b_done = 1;
    end
    chk("b_handshake", 32'(b_done), 32'h1);
  endtask

  // Returns one cycle after the AR handshake (the first RD_WAIT cycle).
  task automatic axi_read(input logic [15:0] a, input logic [31:0] d, input logic [1:0] resp,
                          input bit push);
    bit hs = 0;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = a;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      if (s_axi_arvalid && s_axi_arready) begin
        hs = 1;
        if (push) exp_r.push_back('{cyc + 2 + RD_LAT, d, resp});
      end
      @(posedge clk); #1;
      if (hs) s_axi_arvalid = 1'b0;
    end
    chk("ar_handshake", 32'(hs), 32'h1);
  endtask

  task automatic wait_r();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (s_axi_rvalid && s_axi_rready) done = 1;
    end
    chk("r_handshake", 32'(done), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_r;
    bit got_rvalid;
    rst = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = 4'hF;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
    chk("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid, we_b}), 32'h0);
    chk("rst_resp", 32'({s_axi_bresp, s_axi_rresp}), 32'h0);
    chk("rst_rdata", s_axi_rdata, 32'h0);
    chk("rst_addr_b", addr_b, 32'h0);
    chk("rst_din_b", din_b, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Simultaneous AW/W, then W leading AW by three cycles.
    axi_write(16'h0010, 32'hDEADBEEF, 0, RESP_OKAY, 1);
    axi_write(16'h2004, 32'h12345678, 3, RESP_OKAY, 1);

    // Read with R backpressure: data and arready must hold while rvalid waits.
    s_axi_rready = 1'b0;
    axi_read(16'h2004, 32'h12345678, RESP_OKAY, 1);
    got_rvalid = 0;
    for (int i = 0; i < 20 && !got_rvalid; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) got_rvalid = 1;
    end
    chk("rvalid_seen", 32'(got_rvalid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rdata", s_axi_rdata, 32'h12345678);
      chk("bp_rvalid_arready", 32'({s_axi_rvalid, s_axi_arready}), 32'h2);
    end
    @(posedge clk); #1;
    s_axi_rready = 1'b1;
    wait_r();

    // AW, W and AR together: the write goes first and the read sees its data.
    fork
      axi_write(16'h0020, 32'hCAFEF00D, 0, RESP_OKAY, 1);
      axi_read(16'h0020, 32'hCAFEF00D, RESP_OKAY, 1);
    join
    wait_r();

    // Reset during RD_WAIT drops the read; a fresh unaligned read then works.
    axi_read(16'h0010, 32'h0, RESP_OKAY, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs",
        32'({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, we_b}),
        32'h0);
    saw_r = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) saw_r = 1;
    end
    chk("midrst_no_rvalid", 32'(saw_r), 32'h0);
    axi_read(16'h0013, 32'hDEADBEEF, RESP_OKAY, 1);
    wait_r();

`ifdef PORTB_ADDR_CHECK_EN
    axi_write(16'h4000, 32'hA5A5A5A5, 0, RESP_SLVERR, 0);
    axi_read(16'h4000, 32'h0, RESP_SLVERR, 1);
    wait_r();
`else
    axi_write(16'h4000, 32'hA5A5A5A5, 0, RESP_OKAY, 1);
    axi_read(16'h4000, 32'hA5A5A5A5, RESP_OKAY, 1);
    wait_r();
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_we.size() + exp_b.size() + exp_r.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
